// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: memory loads win
// by default, and an aging counter forces the ALU through after STARVE_LIMIT losses.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              regWR,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] dataWrite,
  output logic              wb_src,
  output logic              alu_forced
);

  typedef enum logic {MEM_PRIO, FORCE_ALU} state_t;

  localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  state_t            state;
  logic [3:0]        loseCnt;
  logic              aluXfer;
  logic              memXfer;
  logic [ADDR_W-1:0] grantRd;
  logic [DATA_W-1:0] grantData;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (state == FORCE_ALU) begin
      alu_ready = alu_valid;
      mem_ready = mem_valid && !alu_valid;
    end else begin
      mem_ready = mem_valid;
      alu_ready = alu_valid && !mem_valid;
    end
  end

  assign aluXfer   = alu_valid && alu_ready;
  assign memXfer   = mem_valid && mem_ready;
  assign grantRd   = memXfer ? mem_rd : alu_rd;
  assign grantData = memXfer ? mem_data : alu_data;

  assign alu_forced = (state == FORCE_ALU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MEM_PRIO;
      loseCnt <= 4'd0;
    end else begin
      case (state)
        MEM_PRIO: begin
          if (alu_valid && mem_valid) begin
            loseCnt <= loseCnt + 4'd1;
            // Switch on the edge where the count reaches the limit, so the ALU
            // is granted on the (limit+1)-th cycle of its request.
            if (loseCnt + 4'd1 >= LIMIT)
              state <= FORCE_ALU;
          end else begin
            loseCnt <= 4'd0;
          end
        end
        FORCE_ALU: begin
          // Either the ALU is granted now or it dropped its request; both end the episode.
          state   <= MEM_PRIO;
          loseCnt <= 4'd0;
        end
        default: begin
          state   <= MEM_PRIO;
          loseCnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWR     <= 1'b0;
      Rd        <= '0;
      dataWrite <= '0;
      wb_src    <= 1'b0;
    end else begin
      regWR <= (aluXfer || memXfer) && (grantRd != ZERO_REG);
      if (aluXfer || memXfer) begin
        Rd        <= grantRd;
        dataWrite <= grantData;
        wb_src    <= memXfer;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: directed vectors push expected writes
// stamped with their output cycle; a forked monitor pops them whenever regWR is high.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [63:0] mem_data = '0;
  logic        mem_ready;
  logic        regWR;
  logic [4:0]  Rd;
  logic [63:0] dataWrite;
  logic        wb_src;
  logic        alu_forced;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [63:0] dat;
    logic        src;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWR(regWR), .Rd(Rd), .dataWrite(dataWrite), .wb_src(wb_src), .alu_forced(alu_forced)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check readies/forced, push expected writes.
  task automatic step(input logic aV, input logic [4:0] aRd, input logic [63:0] aD,
                      input logic mV, input logic [4:0] mRd, input logic [63:0] mD,
                      input logic eA, input logic eM, input logic eF, input logic push);
    exp_t e;
    @(posedge clk);
    #1;
    alu_valid = aV; alu_rd = aRd; alu_data = aD;
    mem_valid = mV; mem_rd = mRd; mem_data = mD;
    #1;
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, eA});
    chk("mem_ready", {63'd0, mem_ready}, {63'd0, eM});
    chk("alu_forced", {63'd0, alu_forced}, {63'd0, eF});
    if (push && eA && aRd != 5'd31) begin
      e.cyc = cyc + 1; e.rd = aRd; e.dat = aD; e.src = 1'b0;
      sb.push_back(e);
    end
    if (push && eM && mRd != 5'd31) begin
      e.cyc = cyc + 1; e.rd = mRd; e.dat = mD; e.src = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && regWR) begin
          if (sb.size() == 0) begin
            chk("unexpected_write_rd", {59'd0, Rd}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            chk("wr_Rd", {59'd0, Rd}, {59'd0, e.rd});
            chk("wr_dataWrite", dataWrite, e.dat);
            chk("wr_src", {63'd0, wb_src}, {63'd0, e.src});
          end
        end
      end
    join_none

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("idle_regWR", {63'd0, regWR}, 64'd0);
      chk("idle_Rd", {59'd0, Rd}, 64'd0);
      chk("idle_dataWrite", dataWrite, 64'd0);
    end

    // Single ALU write
    step(1'b1, 5'd3, 64'h1122334455667788, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    idle();

    // Conflict and aging: MEM wins 3 cycles, ALU forced on the 4th
    step(1'b1, 5'd7, 64'hB7, 1'b1, 5'd1, 64'hA1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd7, 64'hB7, 1'b1, 5'd2, 64'hA2, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd7, 64'hB7, 1'b1, 5'd3, 64'hA3, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd7, 64'hB7, 1'b1, 5'd4, 64'hA4, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 5'd0, 64'd0,  1'b1, 5'd4, 64'hA4, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 64'd0,  1'b1, 5'd5, 64'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 64'd0,  1'b1, 5'd6, 64'hA6, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // X31 drop from MEM
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("x31_regWR", {63'd0, regWR}, 64'd0);

    // ALU grant to X31 still resets the aging counter
    step(1'b1, 5'd31, 64'hC31, 1'b1, 5'd10, 64'hA10, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd31, 64'hC31, 1'b1, 5'd11, 64'hA11, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd31, 64'hC31, 1'b0, 5'd0,  64'd0,   1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd12, 64'hC12, 1'b1, 5'd13, 64'hA13, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd12, 64'hC12, 1'b1, 5'd14, 64'hA14, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd12, 64'hC12, 1'b1, 5'd15, 64'hA15, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd12, 64'hC12, 1'b1, 5'd16, 64'hA16, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 5'd0,  64'd0,   1'b1, 5'd16, 64'hA16, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Back-to-back ALU stream
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'(i), 64'h100 + 64'(i), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    idle();

    // Async reset while FORCE_ALU with a write on the output
    step(1'b1, 5'd2, 64'hD2, 1'b1, 5'd20, 64'hA20, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd2, 64'hD2, 1'b1, 5'd21, 64'hA21, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd2, 64'hD2, 1'b1, 5'd22, 64'hA22, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 mem_rd = 5'd23; mem_data = 64'hA23;
    #1;
    chk("prerst_forced", {63'd0, alu_forced}, 64'd1);
    chk("prerst_regWR", {63'd0, regWR}, 64'd1);
    #1 rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("rst_regWR", {63'd0, regWR}, 64'd0);
    chk("rst_Rd", {59'd0, Rd}, 64'd0);
    chk("rst_dataWrite", dataWrite, 64'd0);
    chk("rst_forced", {63'd0, alu_forced}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 5'd2, 64'hD2, 1'b1, 5'd23, 64'hA23, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    idle();

    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
